core_store_unit: RTL
====================

# core_store_unit

Issues store transactions from the memory stage to the data-memory bus. It sits between the EX/MEM pipeline register and the data port, and is the write-side counterpart of the write-back load extraction. For each store it computes word address, byte enables and lane-shifted write data. It runs the req/gnt/rvalid handshake and splits misaligned halfword and word stores into two word accesses when that feature is enabled.

## Interface
- `DATA_WIDTH`, 32, data and address width; only 32 is supported.
- `clk`  in  1  core clock; every register updates on its rising edge.
- `rstn`  in  1  reset; one clock; reset is synchronous and active-low.
- `st_valid_i`  in  1  a store request is presented.
- `st_op_i`  in  3  store funct3: `STORE_SB`=000, `STORE_SH`=001, `STORE_SW`=010.
- `st_addr_i`  in  32  byte address (rs1 + imm).
- `st_wdata_i`  in  32  rs2 value; data is right-aligned.
- `st_ready_o`  out  1  unit is idle and can accept a request.
- `st_done_o`  out  1  one-cycle pulse when the store completes.
- `st_err_o`  out  1  one-cycle pulse when a store is rejected.
- `data_req_o`  out  1  bus request.
- `data_gnt_i`  in  1  bus grant.
- `data_rvalid_i`  in  1  bus response; for stores this is the write acknowledge.
- `data_we_o`  out  1  write enable; high whenever `data_req_o` is high.
- `data_be_o`  out  4  byte enables.
- `data_addr_o`  out  32  word-aligned address.
- `data_wdata_o`  out  32  lane-aligned write data.

## Operation
- **Accept.** A request is accepted on a rising edge where `st_valid_i && st_ready_o`. On accept, the op, address and data are latched. `st_ready_o` is high only in IDLE.
- **States.** IDLE, REQ1, WAIT1, REQ2, WAIT2.
- **Transitions.**
  - IDLE→REQ1 on accept of a legal store.
  - REQ1→WAIT1 on `data_gnt_i`.
  - WAIT1→IDLE on `data_rvalid_i` for a single access; WAIT1→REQ2 on `data_rvalid_i` for a split access.
  - REQ2→WAIT2 on `data_gnt_i`.
  - WAIT2→IDLE on `data_rvalid_i`.
- **Offset.** Let off = addr[1:0]. The base mask is SB 0001, SH 0011, SW 1111.
- **First access.**
  - `data_addr_o` = {addr[31:2],2'b00}.
  - `data_be_o` = (mask << off)[3:0].
  - `data_wdata_o` = (wdata << 8·off)[31:0].
- **Second access (split only).**
  - `data_addr_o` = first address + 4, with modulo-2^32 wrap: 0xFFFFFFFC wraps to 0x00000000.
  - `data_be_o` = mask >> (4−off).
  - `data_wdata_o` = wdata >> 8·(4−off).
- **Misaligned.** A store is misaligned when it is SH with off=3, or SW with off≠0. SB is never misaligned.
- **Illegal op.** Any other funct3 is illegal. It produces an `st_err_o` pulse in the cycle after accept, generates no bus activity, and the FSM stays in IDLE.
- **Bus output holding.** `data_req_o`, `data_addr_o`, `data_be_o` and `data_wdata_o` are stable from request assertion until the grant cycle inclusive. `data_req_o` deasserts in the cycle after the grant.
- **Ignored responses.** `data_rvalid_i` is ignored in IDLE, REQ1 and REQ2. `data_gnt_i` is ignored outside REQ1 and REQ2.
- **Reset values.**
  - 0: `data_req_o`, `data_we_o`, `data_be_o`, `data_addr_o`, `data_wdata_o`, `st_done_o`, `st_err_o`.
  - 1: `st_ready_o`.
  - State returns to IDLE.
- **Reset mid-operation.** An outstanding transaction is abandoned. A late `data_rvalid_i` after reset is ignored and produces no `st_done_o`.

## Timing
- **Request assertion.** With accept at edge N, `data_req_o` is high from cycle N+1. All bus outputs are registered.
- **Grant.** A grant in the same cycle as the request is legal. Minimum single-access sequence: req in cycle N+1, gnt in N+1, rvalid in N+2.
- **Done.** `st_done_o` pulses in the cycle after the final `data_rvalid_i`. `st_ready_o` rises in that same cycle. A back-to-back accept is then possible at that edge.
- **Split gap.** For a split store, REQ2 asserts `data_req_o` in the cycle after the first `data_rvalid_i`.
- **Minimum latency, accept to `st_done_o`.** Single access: 3 cycles. Split access: 5 cycles.

## Configuration
- `STORE_MISALIGNED_EN` defined: misaligned SH/SW stores are split into two word accesses as above. `st_err_o` only flags illegal ops.
- Not defined:
  - A misaligned SH/SW produces an `st_err_o` pulse in the cycle after accept, issues no bus access, and the FSM stays in IDLE.
  - REQ2 and WAIT2 are not synthesized.

## Test plan
- SB, addr 0x00001003, wdata 0x000000AB, gnt with req, rvalid next cycle -> addr 0x00001000, be 1000, wdata 0xAB000000, `st_done_o` 3 cycles after accept.
- SW, addr 0x00000040, wdata 0xDEADBEEF, gnt held off 3 cycles -> req/addr/be 1111/wdata held stable through the grant; single `st_done_o` pulse.
- With EN: SW, addr 0x00002002, wdata 0x11223344 -> access 1 at 0x00002000 with be 1100, wdata 0x33440000; access 2 at 0x00002004 with be 0011, wdata 0x00001122; one `st_done_o`.
- Without EN: same SW -> `st_err_o` pulse, `data_req_o` never asserted, `st_ready_o` stays 1.
- st_op_i=011 -> `st_err_o` pulse, no bus request.
- `rstn` low during WAIT1, then stray `data_rvalid_i` after release -> all outputs at reset values, no `st_done_o`, `st_ready_o`=1.

Source files
------------

// File: rtl/core_store_unit.sv
// Store issue unit: latches a store, drives word address, byte enables and lane-shifted data on the data bus.
// Optional STORE_MISALIGNED_EN splits misaligned SH/SW into two word accesses; otherwise they are rejected.
//   state | meaning
//   IDLE  | ready for a new store
//   REQ1  | first (or only) access requested, waiting for grant
//   WAIT1 | first access granted, waiting for write acknowledge
//   REQ2  | second access of a split store requested
//   WAIT2 | second access granted, waiting for write acknowledge
module core_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  st_valid_i,
    input  logic [2:0]            st_op_i,
    input  logic [DATA_WIDTH-1:0] st_addr_i,
    input  logic [DATA_WIDTH-1:0] st_wdata_i,
    output logic                  st_ready_o,
    output logic                  st_done_o,
    output logic                  st_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o
);

    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        WAIT1 = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    data_req_q, data_req_d;
    logic [DATA_WIDTH-1:0]   data_addr_q, data_addr_d;
    logic [3:0]              data_be_q, data_be_d;
    logic [DATA_WIDTH-1:0]   data_wdata_q, data_wdata_d;
    logic                    st_done_q, st_done_d;
    logic                    st_err_q, st_err_d;

    logic                    accept;
    logic                    op_legal;
    logic                    misaligned;
    logic                    reject;
    logic [1:0]              off;
    logic [3:0]              base_mask;
    logic [3:0]              be_lo;
    logic [DATA_WIDTH-1:0]   wdata_lo;

`ifdef STORE_MISALIGNED_EN
    logic                    split_q, split_d;
    logic [3:0]              be_hi_q, be_hi_d;
    logic [DATA_WIDTH-1:0]   wdata_hi_q, wdata_hi_d;
    logic [3:0]              be_hi;
    logic [DATA_WIDTH-1:0]   wdata_hi;
`endif

    always_comb begin
        off       = st_addr_i[1:0];
        op_legal  = 1'b1;
        base_mask = 4'b0000;
        case (st_op_i)
            STORE_SB: base_mask = 4'b0001;
            STORE_SH: base_mask = 4'b0011;
            STORE_SW: base_mask = 4'b1111;
            default:  op_legal  = 1'b0;
        endcase
        misaligned = ((st_op_i == STORE_SH) && (off == 2'd3)) ||
                     ((st_op_i == STORE_SW) && (off != 2'd0));
        be_lo    = base_mask << off;
        wdata_lo = st_wdata_i << {off, 3'b000};
`ifdef STORE_MISALIGNED_EN
        be_hi    = base_mask >> (3'd4 - {1'b0, off});
        wdata_hi = st_wdata_i >> (6'd32 - {1'b0, off, 3'b000});
        reject   = !op_legal;
`else
        reject   = !op_legal || misaligned;
`endif
        accept = st_valid_i && (state_q == IDLE);
    end

    always_comb begin
        state_d      = state_q;
        data_req_d   = data_req_q;
        data_addr_d  = data_addr_q;
        data_be_d    = data_be_q;
        data_wdata_d = data_wdata_q;
        st_done_d    = 1'b0;
        st_err_d     = 1'b0;
`ifdef STORE_MISALIGNED_EN
        split_d      = split_q;
        be_hi_d      = be_hi_q;
        wdata_hi_d   = wdata_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        st_err_d = 1'b1;
                    end else begin
                        state_d      = REQ1;
                        data_req_d   = 1'b1;
                        data_addr_d  = {st_addr_i[DATA_WIDTH-1:2], 2'b00};
                        data_be_d    = be_lo;
                        data_wdata_d = wdata_lo;
`ifdef STORE_MISALIGNED_EN
                        split_d      = misaligned;
                        be_hi_d      = be_hi;
                        wdata_hi_d   = wdata_hi;
`endif
                    end
                end
            end
            REQ1: begin
                if (data_gnt_i) begin
                    state_d    = WAIT1;
                    data_req_d = 1'b0;
                end
            end
            WAIT1: begin
                if (data_rvalid_i) begin
`ifdef STORE_MISALIGNED_EN
                    if (split_q) begin
                        // Address register still holds the first word; +4 wraps naturally.
                        state_d      = REQ2;
                        data_req_d   = 1'b1;
                        data_addr_d  = data_addr_q + 32'd4;
                        data_be_d    = be_hi_q;
                        data_wdata_d = wdata_hi_q;
                    end else begin
                        state_d   = IDLE;
                        st_done_d = 1'b1;
                    end
`else
                    state_d   = IDLE;
                    st_done_d = 1'b1;
`endif
                end
            end
`ifdef STORE_MISALIGNED_EN
            REQ2: begin
                if (data_gnt_i) begin
                    state_d    = WAIT2;
                    data_req_d = 1'b0;
                end
            end
            WAIT2: begin
                if (data_rvalid_i) begin
                    state_d   = IDLE;
                    st_done_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            data_req_q   <= 1'b0;
            data_addr_q  <= '0;
            data_be_q    <= 4'b0000;
            data_wdata_q <= '0;
            st_done_q    <= 1'b0;
            st_err_q     <= 1'b0;
`ifdef STORE_MISALIGNED_EN
            split_q      <= 1'b0;
            be_hi_q      <= 4'b0000;
            wdata_hi_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            data_req_q   <= data_req_d;
            data_addr_q  <= data_addr_d;
            data_be_q    <= data_be_d;
            data_wdata_q <= data_wdata_d;
            st_done_q    <= st_done_d;
            st_err_q     <= st_err_d;
`ifdef STORE_MISALIGNED_EN
            split_q      <= split_d;
            be_hi_q      <= be_hi_d;
            wdata_hi_q   <= wdata_hi_d;
`endif
        end
    end

    assign st_ready_o   = (state_q == IDLE);
    assign st_done_o    = st_done_q;
    assign st_err_o     = st_err_q;
    assign data_req_o   = data_req_q;
    assign data_we_o    = data_req_q;
    assign data_be_o    = data_be_q;
    assign data_addr_o  = data_addr_q;
    assign data_wdata_o = data_wdata_q;

endmodule
